// File: rtl/wb32_to_wb8_bridge_pkg.sv
// Shared types and constants for the 32-to-8-bit Wishbone bridge.
// Holds the FSM encoding, lane count and timeout fill byte.
package wb32_to_wb8_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LANES = 4;
  localparam logic [7:0] TMO_FILL = 8'hFF;

  function automatic logic [7:0] lane_byte(
    input logic [31:0] w,
    input logic [1:0]  l
  );
    return w[{l, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/wb32_to_wb8_bridge_lane_picker.sv
// Priority encoder: lowest remaining byte-enable bit to a lane number.
// valid is low when no lane is left.
module wb_sel_lane_picker
  import wb32_to_wb8_bridge_pkg::*;
(
  input  logic [LANES-1:0] sel_i,
  output logic             valid_o,
  output logic [1:0]       lane_o
);

  // Lowest set bit wins.
  always_comb begin
    valid_o = 1'b1;
    lane_o  = 2'd0;
    if (sel_i[0])      lane_o = 2'd0;
    else if (sel_i[1]) lane_o = 2'd1;
    else if (sel_i[2]) lane_o = 2'd2;
    else if (sel_i[3]) lane_o = 2'd3;
    else               valid_o = 1'b0;
  end

endmodule

// File: rtl/wb32_to_wb8_bridge.sv
// Wishbone B4 pipelined 32-bit slave to 8-bit master width bridge.
// One 8-bit transfer per selected lane, lane 0 first; one reply.
module wb32_to_wb8_bridge
  import wb32_to_wb8_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  I_clk,
  input  logic                  I_reset,
  input  logic                  I_wb_cyc,
  input  logic                  I_wb_stb,
  input  logic                  I_wb_we,
  input  logic [29:0]           I_wb_adr,
  input  logic [31:0]           I_wb_dat,
  input  logic [3:0]            I_wb_sel,
  output logic [31:0]           O_wb_dat,
  output logic                  O_wb_ack,
  output logic                  O_wb_err,
  output logic                  O_wb_stall,
  output logic                  O_wb8_cyc,
  output logic                  O_wb8_stb,
  output logic                  O_wb8_we,
  output logic [ADDR_WIDTH-1:0] O_wb8_adr,
  output logic [7:0]            O_wb8_dat,
  input  logic [7:0]            I_wb8_dat,
  input  logic                  I_wb8_ack,
  input  logic                  I_wb8_stall
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [29:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [LANES-1:0]  sel_q, sel_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic              err_q, err_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [LANES-1:0]  sel_rem;
  logic [LANES-1:0]  pick_sel;
  logic              pick_vld;
  logic [1:0]        pick_lane;
  logic              tmo_hit;
  logic              lane_done;
  logic              lane_tmo;
  logic [31:0]       adr_full;

  assign sel_rem  = sel_q & ~(4'b0001 << lane_q);
  assign pick_sel = (state_q == ST_IDLE) ? I_wb_sel : sel_rem;
  assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);
  assign adr_full = {adr_q, lane_q};

  wb_sel_lane_picker u_pick (
    .sel_i   (pick_sel),
    .valid_o (pick_vld),
    .lane_o  (pick_lane)
  );

  // State and datapath registers.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      lane_q  <= '0;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      lane_q  <= lane_d;
      rbuf_q  <= rbuf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, lane sequencing and bus outputs.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    lane_d     = lane_q;
    rbuf_d     = rbuf_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    lane_done  = 1'b0;
    lane_tmo   = 1'b0;
    O_wb_dat   = '0;
    O_wb_ack   = 1'b0;
    O_wb_err   = 1'b0;
    O_wb_stall = 1'b1;
    O_wb8_cyc  = 1'b0;
    O_wb8_stb  = 1'b0;
    O_wb8_we   = 1'b0;
    O_wb8_adr  = '0;
    O_wb8_dat  = '0;

    unique case (state_q)
      ST_IDLE: begin
        O_wb_stall = 1'b0;
        if (I_wb_cyc && I_wb_stb) begin
          we_d   = I_wb_we;
          adr_d  = I_wb_adr;
          dat_d  = I_wb_dat;
          sel_d  = I_wb_sel;
          rbuf_d = '0;
          err_d  = 1'b0;
          cnt_d  = '0;
          lane_d = pick_lane;
          state_d = pick_vld ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        O_wb8_cyc = 1'b1;
        O_wb8_stb = 1'b1;
        O_wb8_we  = we_q;
        O_wb8_adr = ADDR_WIDTH'(adr_full);
        O_wb8_dat = lane_byte(dat_q, lane_q);
        if (!I_wb_cyc) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (!I_wb8_stall && I_wb8_ack) begin
            lane_done = 1'b1;
          end else if (tmo_hit) begin
            lane_done = 1'b1;
            lane_tmo  = 1'b1;
          end else if (!I_wb8_stall) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        O_wb8_cyc = 1'b1;
        if (!I_wb_cyc) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (I_wb8_ack) begin
            lane_done = 1'b1;
          end else if (tmo_hit) begin
            lane_done = 1'b1;
            lane_tmo  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        O_wb_dat = rbuf_q;
        O_wb_ack = I_wb_cyc && !err_q;
        O_wb_err = I_wb_cyc && err_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (lane_done) begin
      if (!we_q) begin
        rbuf_d[{lane_q, 3'b000} +: 8] = lane_tmo ? TMO_FILL : I_wb8_dat;
      end
      err_d  = err_q | lane_tmo;
      sel_d  = sel_rem;
      cnt_d  = '0;
      lane_d = pick_lane;
      state_d = pick_vld ? ST_ISSUE : ST_DONE;
    end
  end

endmodule

// File: tb/tb_wb32_to_wb8_bridge.sv
// Directed bench for wb32_to_wb8_bridge with an 8-bit RAM model.
// Second instance with a short timeout faces a device that never acks.
module tb_wb32_to_wb8_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [29:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic        ack_o, err_o, stall_o;
  logic        w8_cyc, w8_stb, w8_we;
  logic [31:0] w8_adr;
  logic [7:0]  w8_dato, w8_dati;
  logic        w8_ack, w8_stall;

  logic        t_cyc, t_stb;
  logic [31:0] t_dat;
  logic        t_ack, t_err, t_stall;
  logic        t8_cyc, t8_stb, t8_we;
  logic [31:0] t8_adr;
  logic [7:0]  t8_dato;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb32_to_wb8_bridge dut (
    .I_clk(clk), .I_reset(rst),
    .I_wb_cyc(cyc), .I_wb_stb(stb), .I_wb_we(we),
    .I_wb_adr(adr), .I_wb_dat(dat), .I_wb_sel(sel),
    .O_wb_dat(dat_o), .O_wb_ack(ack_o), .O_wb_err(err_o),
    .O_wb_stall(stall_o),
    .O_wb8_cyc(w8_cyc), .O_wb8_stb(w8_stb), .O_wb8_we(w8_we),
    .O_wb8_adr(w8_adr), .O_wb8_dat(w8_dato),
    .I_wb8_dat(w8_dati), .I_wb8_ack(w8_ack), .I_wb8_stall(w8_stall)
  );

  wb32_to_wb8_bridge #(.TIMEOUT(4)) dut_t (
    .I_clk(clk), .I_reset(rst),
    .I_wb_cyc(t_cyc), .I_wb_stb(t_stb), .I_wb_we(we),
    .I_wb_adr(adr), .I_wb_dat(dat), .I_wb_sel(sel),
    .O_wb_dat(t_dat), .O_wb_ack(t_ack), .O_wb_err(t_err),
    .O_wb_stall(t_stall),
    .O_wb8_cyc(t8_cyc), .O_wb8_stb(t8_stb), .O_wb8_we(t8_we),
    .O_wb8_adr(t8_adr), .O_wb8_dat(t8_dato),
    .I_wb8_dat(8'h00), .I_wb8_ack(1'b0), .I_wb8_stall(1'b0)
  );

  // 8-bit RAM device: registered or combinational ack, optional stall.
  logic [7:0]  mem [16];
  logic        comb_mode = 1'b0;
  logic        noack = 1'b0;
  int          stall_req = 0;
  int          stall_used = 0;
  logic        ack_r = 1'b0;
  logic [7:0]  rdat_r = 8'h00;
  logic [15:0] log_q[$];

  assign w8_stall = w8_cyc && (stall_used < stall_req);
  assign w8_ack   = noack ? 1'b0 :
                    comb_mode ? (w8_stb && !w8_stall) : ack_r;
  assign w8_dati  = comb_mode ? mem[w8_adr[3:0]] : rdat_r;

  always @(posedge clk) begin
    ack_r <= 1'b0;
    if (!w8_cyc) stall_used <= 0;
    else if (w8_stb && w8_stall) stall_used <= stall_used + 1;
    if (w8_stb && !w8_stall) begin
      ack_r  <= !comb_mode;
      rdat_r <= mem[w8_adr[3:0]];
      if (w8_we) mem[w8_adr[3:0]] <= w8_dato;
      log_q.push_back({w8_adr[7:0], w8_dato});
    end
  end

  // Protocol watchers sampled mid-cycle.
  int   unstable = 0, both_hi = 0, back2back = 0;
  logic p_hold = 1'b0, p_resp = 1'b0;
  logic [31:0] p_adr;
  logic [7:0]  p_dat;

  always @(negedge clk) begin
    if (p_hold && !(w8_stb && w8_adr == p_adr && w8_dato == p_dat))
      unstable = unstable + 1;
    p_hold = w8_stb && w8_stall;
    p_adr  = w8_adr;
    p_dat  = w8_dato;
    if (ack_o && err_o) both_hi = both_hi + 1;
    if ((ack_o || err_o) && p_resp) back2back = back2back + 1;
    p_resp = ack_o || err_o;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int stall_lo, cyc8_n;

  task automatic do_req(input logic r_we, input logic [29:0] r_adr,
                        input logic [31:0] r_dat, input logic [3:0] r_sel,
                        output logic [31:0] rd, output int lat,
                        output int nack, output int nerr);
    lat = -1; nack = 0; nerr = 0; rd = '0;
    stall_lo = 0; cyc8_n = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = r_we;
    adr = r_adr; dat = r_dat; sel = r_sel;
    @(negedge clk);
    stb = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (w8_cyc) cyc8_n++;
      if ((ack_o || err_o) && lat < 0) begin
        lat = c;
        rd  = dat_o;
      end
      if (ack_o) nack++;
      if (err_o) nerr++;
      if (lat < 0 || c == lat) stall_lo += (stall_o ? 0 : 1);
      if (lat >= 0 && c >= lat + 2) break;
      @(negedge clk);
    end
    cyc = 1'b0;
  endtask

  logic [31:0] rd;
  int lat, nack, nerr, base;

  initial begin
    rst = 1'b1; cyc = 0; stb = 0; we = 0;
    adr = '0; dat = '0; sel = '0;
    t_cyc = 0; t_stb = 0;
    repeat (3) @(negedge clk);
    chk("rst_dat", {32'h0, dat_o}, 64'h0);
    chk("rst_ctl", {58'h0, ack_o, err_o, stall_o, w8_cyc, w8_stb, w8_we}, 64'h0);
    chk("rst_w8", {24'h0, w8_adr, w8_dato}, 64'h0);
    chk("rst_t", {29'h0, t_dat, t_ack, t_err, t8_cyc}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    base = log_q.size();
    do_req(1'b1, 30'd0, 32'h87654321, 4'hF, rd, lat, nack, nerr);
    chk("wr_lat", lat, 9);
    chk("wr_nack", nack, 1);
    chk("wr_cnt", log_q.size() - base, 4);
    chk("wr_b0", log_q[base + 0], 16'h0021);
    chk("wr_b1", log_q[base + 1], 16'h0143);
    chk("wr_b2", log_q[base + 2], 16'h0265);
    chk("wr_b3", log_q[base + 3], 16'h0387);

    do_req(1'b0, 30'd0, 32'h0, 4'hF, rd, lat, nack, nerr);
    chk("rd_dat", rd, 32'h87654321);
    chk("rd_lat", lat, 9);
    chk("rd_nack", nack, 1);

    do_req(1'b1, 30'd0, 32'hddccbbaa, 4'hF, rd, lat, nack, nerr);
    base = log_q.size();
    do_req(1'b0, 30'd0, 32'h0, 4'b1010, rd, lat, nack, nerr);
    chk("sp_dat", rd, 32'hdd00bb00);
    chk("sp_lat", lat, 5);
    chk("sp_cnt", log_q.size() - base, 2);
    chk("sp_a1", {log_q[base + 0][15:8]}, 8'h01);
    chk("sp_a3", {log_q[base + 1][15:8]}, 8'h03);

    stall_req = 3;
    unstable = 0;
    do_req(1'b0, 30'd0, 32'h0, 4'hF, rd, lat, nack, nerr);
    stall_req = 0;
    chk("st_lat", lat, 12);
    chk("st_dat", rd, 32'hddccbbaa);
    chk("st_hold", unstable, 0);
    chk("st_stall", stall_lo, 0);

    comb_mode = 1'b1;
    do_req(1'b1, 30'd0, 32'h0badf00d, 4'hF, rd, lat, nack, nerr);
    chk("cb_wlat", lat, 5);
    do_req(1'b0, 30'd0, 32'h0, 4'hF, rd, lat, nack, nerr);
    chk("cb_rlat", lat, 5);
    chk("cb_dat", rd, 32'h0badf00d);
    comb_mode = 1'b0;

    do_req(1'b1, 30'd2, 32'h12345678, 4'h0, rd, lat, nack, nerr);
    chk("s0_lat", lat, 1);
    chk("s0_cyc8", cyc8_n, 0);
    chk("s0_nack", nack, 1);

    noack = 1'b1;
    nack = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = '0; sel = 4'h1;
    @(negedge clk);
    stb = 0;
    @(negedge clk);
    chk("ab_wait", {62'h0, w8_cyc, w8_stb}, 64'h2);
    cyc = 0;
    @(negedge clk);
    chk("ab_idle", {61'h0, w8_cyc, w8_stb, stall_o}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      if (ack_o || err_o) nack++;
      @(negedge clk);
    end
    chk("ab_noack", nack, 0);
    noack = 1'b0;

    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = '0; sel = 4'hF;
    @(negedge clk);
    stb = 0;
    chk("rs_issue", w8_stb, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_ctl", {58'h0, ack_o, err_o, stall_o, w8_cyc, w8_stb, w8_we}, 64'h0);
    chk("rs_dat", {w8_adr, dat_o}, 64'h0);
    rst = 1'b0; cyc = 0;
    @(negedge clk);

    lat = -1; nack = 0; nerr = 0; rd = '0;
    t_cyc = 1; t_stb = 1; we = 0; adr = '0; sel = 4'h1;
    @(negedge clk);
    t_stb = 0;
    for (int c = 1; c <= 20; c++) begin
      if (t_ack) nack++;
      if (t_err) begin
        nerr++;
        if (lat < 0) begin lat = c; rd = t_dat; end
      end
      @(negedge clk);
    end
    t_cyc = 0;
    chk("to_lat", lat, 5);
    chk("to_dat", rd, 32'h000000FF);
    chk("to_nerr", nerr, 1);
    chk("to_nack", nack, 0);

    chk("both_hi", both_hi, 0);
    chk("back2back", back2back, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
